// File: rtl/reg32.sv
// reg32: WIDTH-bit load/hold register with load enable and asynchronous
// active-low reset.
//
// Parameters:
//   WIDTH       - data width of D and Q
//   RESET_VALUE - value held in the register while rst is low
// Ports:
//   clk - clock; the register updates on its rising edge
//   rst - asynchronous reset, active low (rst=0 resets)
//   D   - data to be stored
//   en  - load enable, active high, sampled at the rising edge of clk
//   Q   - stored value, driven straight from the register
module reg32 #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next value: load the whole word when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = D;
    end
  end

  // Storage register; reset wins over a simultaneous load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_reg32.sv
// tb_reg32: self-checking bench for reg32. Runs a default 32-bit instance and
// an 8-bit instance with a non-zero reset value against a behavioural model,
// with directed scenarios followed by randomized load/hold/reset traffic.
module tb_reg32;

  localparam logic [7:0] RV8 = 8'hA5;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] D;
  logic [31:0] Q;
  logic [7:0]  Q8;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  // Behavioural model: the last word loaded since the last reset.
  logic [31:0] exp32 = 32'h0;
  logic [7:0]  exp8  = RV8;

  reg32 u_dut (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .en  (en),
    .Q   (Q)
  );

  reg32 #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .D   (D[7:0]),
    .en  (en),
    .Q   (Q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a rising edge with reset released and enable high captures D.
  always @(posedge clk) begin
    if (rst === 1'b1 && en === 1'b1) begin
      exp32 = D;
      exp8  = D[7:0];
    end
  end

  // Model: any time reset is low, the stored word is the reset value.
  always @(rst) begin
    if (rst !== 1'b1) begin
      exp32 = 32'h0;
      exp8  = RV8;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("cycle_q32", Q, exp32);
      chk("cycle_q8", {24'h0, Q8}, {24'h0, exp8});
    end
  end

  task automatic drive(input logic r, input logic e, input logic [31:0] d);
    @(negedge clk);
    #2;
    rst = r;
    en  = e;
    D   = d;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    D   = 32'h0;
    repeat (2) @(posedge clk);

    // Reset state.
    @(negedge clk);
    #2;
    checking = 1'b1;
    chk("reset_q32", Q, 32'h0);
    chk("reset_q8", {24'h0, Q8}, 32'h0000_00A5);

    // Reset then load.
    drive(1'b1, 1'b1, 32'hBA09F533);
    @(posedge clk); #1;
    chk("first_load", Q, 32'hBA09F533);
    chk("first_load_q8", {24'h0, Q8}, 32'h0000_0033);

    // Back-to-back load.
    drive(1'b1, 1'b1, 32'h7887BA09);
    @(posedge clk); #1;
    chk("b2b_load", Q, 32'h7887BA09);

    // Hold with en=0.
    drive(1'b1, 1'b0, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("hold", Q, 32'h7887BA09);

    // Asynchronous reset while clk is low.
    drive(1'b0, 1'b0, 32'hFFFFFFFF);
    #1;
    chk("async_reset_q32", Q, 32'h0);
    chk("async_reset_q8", {24'h0, Q8}, 32'h0000_00A5);

    // Reset priority over a simultaneous load, then release.
    drive(1'b0, 1'b1, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("reset_priority", Q, 32'h0);
    drive(1'b1, 1'b1, 32'hFFFFFFFF);
    #1;
    chk("released_no_edge", Q, 32'h0);
    @(posedge clk); #1;
    chk("load_after_release", Q, 32'hFFFFFFFF);

    // Mid-cycle D changes do not reach Q before the next edge.
    drive(1'b1, 1'b1, 32'h12345678);
    @(posedge clk); #1;
    chk("mid_pre", Q, 32'h12345678);
    #1 D = 32'h0BADF00D;
    @(negedge clk); #1;
    chk("mid_high_change", Q, 32'h12345678);
    D = 32'hCAFEBABE;
    #2;
    chk("mid_low_change", Q, 32'h12345678);
    @(posedge clk); #1;
    chk("mid_next_edge", Q, 32'hCAFEBABE);

    // Reset asserted in the same timestep as a rising edge.
    drive(1'b1, 1'b1, 32'h55555555);
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk("edge_reset", Q, 32'h0);
    drive(1'b1, 1'b0, 32'h33333333);
    @(posedge clk); #1;
    chk("after_reset_en0", Q, 32'h0);

    // Randomized traffic; the cycle compare does the checking.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #2 D = $urandom;
        if ($urandom_range(0, 1) == 1) en = ~en;
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running at %0t, expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule
